pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Front end of the instruction path: owns the PC register and fetches from instruction memory.
//  Supplies pcPlus4/pcBranch to the PC-select mux and consumes the selected pc back as pcNext.
//  Fetch uses a req/ready handshake with imem and a valid/stall handshake with the decode datapath.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  CNT_W         32             width of the accepted-instruction counter
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  pcNext       in   32     selected next PC (pcMux output)
//  immB         in   32     sign-extended branch offset of the current instr
//  pc           out  32     current PC register
//  pcPlus4      out  32     pc + 4
//  pcBranch     out  32     pc + immB
//  imemReq      out  1      fetch request valid
//  imemAddr     out  32     fetch address (== pc while imemReq)
//  imemReady    in   1      imem returns imemRdata this cycle (ignored unless imemReq)
//  imemRdata    in   32     fetched word
//  instr        out  32     held instruction for decode
//  instrValid   out  1      instr valid for decode
//  stall        in   1      decode cannot accept this cycle
//  instrCount   out  CNT_W  number of accepted instructions
//  misaligned   out  1      sticky fault flag (MISALIGN_TRAP_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (sync, high): pc=RESET_VECTOR, state=IDLE, instr=0, instrValid=0, imemReq=0,
//   instrCount=0, misaligned=0. Reset wins over every other event, including mid-handshake.
//  Combinational: pcPlus4=pc+32'd4, pcBranch=pc+immB; both mod 2^32, carry dropped
//   (32'hFFFF_FFFC+4 -> 0). imemAddr=pc.
//  FSM states IDLE, REQ, VALID (+FAULT with macro):
//   IDLE : all handshakes low; next cycle -> REQ unconditionally.
//   REQ  : imemReq=1. imemReady=1 -> instr<=imemRdata, -> VALID. Else stay, pc stable.
//   VALID: instrValid=1, imemReq=0. stall=0 -> accept: pc<=pcNext, instrCount+=1,
//          -> REQ. stall=1 -> hold pc, instr, state.
//  Latency: REQ with imemReady=1 -> instrValid next cycle; accept -> imemReq next cycle.
//   Min 2 cycles per instruction with zero-wait imem and no stall.
//  imemRdata sampled only in REQ with imemReady=1; imemReady outside REQ has no effect.
//  instrCount wraps 2^CNT_W-1 -> 0 silently.
//  pcNext, immB sampled only on accept; undefined values elsewhere must not affect state.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: on accept with pcNext[1:0]!=0 -> pc<=pcNext, state FAULT,
//   misaligned<=1, instrCount still increments. FAULT: imemReq=0, instrValid=0,
//   held until reset. Aligned accepts behave as normal.
//  MISALIGN_TRAP_EN undefined: pc<={pcNext[31:2],2'b00} on every accept, no FAULT
//   state, misaligned tied 0.
// TESTING
//  1 Reset RESET_VECTOR=0, imemReady=1, stall=0, pcNext=pcPlus4: pc 0,4,8 with instrValid
//    every 2nd cycle; instrCount=3 after 3 accepts.
//  2 Hold imemReady=0 for 5 cycles in REQ: imemReq stays 1, imemAddr stable,
//    instrValid=0; ready on cycle 6 -> instr=imemRdata next cycle.
//  3 stall=1 for 4 cycles in VALID with instr=32'h00500093: instr, pc, instrCount
//    unchanged, imemReq=0; stall=0 -> pc<=pcNext, count+1.
//  4 pc=32'h100, immB=32'hFFFF_FFF0: pcBranch=32'h0F0; pcNext=pcBranch accept -> imemAddr=32'h0F0.
//  5 pc=32'hFFFF_FFFC: pcPlus4=0; accept -> pc=0, fetch from 0.
//  6 pcNext=32'h102 accept: with macro -> misaligned=1, FAULT, imemReq=0 until reset;
//    without -> pc=32'h100. Reset asserted during REQ -> all outputs to reset values next edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Front end of the instruction path. Owns the PC register, fetches one word at
// a time from instruction memory and holds it for the decode datapath until
// decode accepts it. The PC-select mux lives outside this block: it receives
// pcPlus4/pcBranch from here and returns its choice on pcNext.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined   : an accept whose pcNext has a nonzero low two bits loads that PC,
//               raises the sticky misaligned flag and parks the unit in FAULT
//               until reset.
//   undefined : the low two bits of pcNext are cleared on every accept, there
//               is no FAULT state and misaligned is tied low.
//
// Parameters
//   RESET_VECTOR  PC loaded on reset
//   CNT_W         width of the accepted-instruction counter (wraps silently)
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high; wins over everything
//   pcNext      in   32     selected next PC, sampled only on accept
//   immB        in   32     sign-extended branch offset of the current instr
//   pc          out  32     current PC register
//   pcPlus4     out  32     pc + 4 (mod 2^32)
//   pcBranch    out  32     pc + immB (mod 2^32)
//   imemReq     out  1      fetch request valid
//   imemAddr    out  32     fetch address, always equal to pc
//   imemReady   in   1      imem delivers imemRdata this cycle
//   imemRdata   in   32     fetched word
//   instr       out  32     held instruction for decode
//   instrValid  out  1      instr is valid for decode
//   stall       in   1      decode cannot accept this cycle
//   instrCount  out  CNT_W  number of accepted instructions
//   misaligned  out  1      sticky misaligned-PC fault flag
//   state_dbg   out  2      current FSM state (IDLE=0, REQ=1, VALID=2, FAULT=3)
//
// Handshakes
//   imem side  : a word transfers on a cycle where imemReq=1 and imemReady=1.
//                imemReady with imemReq low is ignored.
//   decode side: an instruction is accepted on a cycle where instrValid=1 and
//                stall=0. While stalled, instr and pc are held unchanged.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pcNext,
  input  logic [31:0]      immB,
  output logic [31:0]      pc,
  output logic [31:0]      pcPlus4,
  output logic [31:0]      pcBranch,
  output logic             imemReq,
  output logic [31:0]      imemAddr,
  input  logic             imemReady,
  input  logic [31:0]      imemRdata,
  output logic [31:0]      instr,
  output logic             instrValid,
  input  logic             stall,
  output logic [CNT_W-1:0] instrCount,
  output logic             misaligned,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
`ifdef MISALIGN_TRAP_EN
    , S_FAULT = 2'd3
`endif
  } state_t;

  state_t state;

  // Next-PC candidates; carry out of bit 31 is dropped by the 32-bit result.
  assign pcPlus4   = pc + 32'd4;
  assign pcBranch  = pc + immB;
  assign imemAddr  = pc;
  assign state_dbg = state;

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q;
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  // imemReq and instrValid are registered alongside the state so each is a
  // clean flop output; they are updated on exactly the transitions that enter
  // or leave REQ and VALID respectively.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_VECTOR;
      instr      <= '0;
      instrValid <= 1'b0;
      imemReq    <= 1'b0;
      instrCount <= '0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state)
        // One quiet cycle after reset before the first fetch.
        S_IDLE: begin
          state   <= S_REQ;
          imemReq <= 1'b1;
        end

        // Request outstanding; pc is held until imem answers.
        S_REQ: begin
          if (imemReady) begin
            instr      <= imemRdata;
            imemReq    <= 1'b0;
            instrValid <= 1'b1;
            state      <= S_VALID;
          end
        end

        // Instruction presented to decode; stall holds everything.
        S_VALID: begin
          if (!stall) begin
            instrCount <= instrCount + CNT_W'(1);
            instrValid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            pc <= pcNext;
            if (pcNext[1:0] != 2'b00) begin
              misaligned_q <= 1'b1;
              state        <= S_FAULT;
            end else begin
              imemReq <= 1'b1;
              state   <= S_REQ;
            end
`else
            // Word alignment is forced rather than trapped.
            pc      <= pcNext & 32'hFFFF_FFFC;
            imemReq <= 1'b1;
            state   <= S_REQ;
`endif
          end
        end

`ifdef MISALIGN_TRAP_EN
        // Terminal until reset: no fetch, nothing presented to decode.
        S_FAULT: begin
          state <= S_FAULT;
        end
`endif

        default: begin
          state      <= S_IDLE;
          imemReq    <= 1'b0;
          instrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int CNT_W = 4;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int M_PLUS4  = 0;
  localparam int M_BRANCH = 1;
  localparam int M_MAN    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [31:0]      pcNext;
  logic [31:0]      immB;
  logic [31:0]      pc;
  logic [31:0]      pcPlus4;
  logic [31:0]      pcBranch;
  logic             imemReq;
  logic [31:0]      imemAddr;
  logic             imemReady;
  logic [31:0]      imemRdata;
  logic [31:0]      instr;
  logic             instrValid;
  logic             stall;
  logic [CNT_W-1:0] instrCount;
  logic             misaligned;
  logic [1:0]       state_dbg;

  // Stimulus controls
  int          mode;
  logic [31:0] pc_next_man;
  logic        ovr_en;
  logic [31:0] ovr_word;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // The PC mux outside the unit.
  assign pcNext    = (mode == M_PLUS4)  ? pcPlus4 :
                     (mode == M_BRANCH) ? pcBranch : pc_next_man;
  assign imemRdata = ovr_en ? ovr_word : mem_word(imemAddr);

  pc_fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pcNext     (pcNext),
    .immB       (immB),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .pcBranch   (pcBranch),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemReady  (imemReady),
    .imemRdata  (imemRdata),
    .instr      (instr),
    .instrValid (instrValid),
    .stall      (stall),
    .instrCount (instrCount),
    .misaligned (misaligned),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the transaction view: is a fetch outstanding, is a word being held
  // for decode, has the unit trapped. Updated from the inputs seen at each edge.
  logic [31:0]      m_pc;
  logic [31:0]      m_instr;
  logic             m_req;
  logic             m_have;
  logic             m_fault;
  logic [CNT_W-1:0] m_count;
  bit               model_on = 1'b0;

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_req = 1'b0; m_have = 1'b0;
      m_fault = 1'b0; m_count = '0; model_on = 1'b1;
    end else if (model_on && !m_fault) begin
      if (!m_req && !m_have) begin
        m_req = 1'b1;                        // first fetch after reset
      end else if (m_req) begin
        if (imemReady) begin
          m_instr = ovr_en ? ovr_word : mem_word(m_pc);
          m_have  = 1'b1;
          m_req   = 1'b0;
        end
      end else if (!stall) begin             // holding a word, decode takes it
        nxt = (mode == M_PLUS4)  ? m_pc + 32'd4 :
              (mode == M_BRANCH) ? m_pc + immB  : pc_next_man;
        m_count = m_count + 1'b1;
        m_have  = 1'b0;
        if (TRAP_EN && nxt[1:0] != 2'b00) begin
          m_pc    = nxt;
          m_fault = 1'b1;
        end else begin
          m_pc  = TRAP_EN ? nxt : {nxt[31:2], 2'b00};
          m_req = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("pc",         pc,                 m_pc);
      check("pcPlus4",    pcPlus4,            m_pc + 32'd4);
      check("pcBranch",   pcBranch,           m_pc + immB);
      check("imemAddr",   imemAddr,           m_pc);
      check("imemReq",    {31'b0, imemReq},    {31'b0, m_req});
      check("instrValid", {31'b0, instrValid}, {31'b0, m_have});
      check("instr",      instr,              m_instr);
      check("instrCount", {{(32-CNT_W){1'b0}}, instrCount}, {{(32-CNT_W){1'b0}}, m_count});
      check("misaligned", {31'b0, misaligned}, {31'b0, m_fault});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (instrValid !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (instrValid !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_valid: instrValid %b after %0d cycles, required 1", instrValid, budget);
    end
  endtask

  task automatic accept_n(input int n);
    for (int i = 0; i < n; i++) begin
      wait_valid(20);
      tick(1);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; imemReady = 1'b1; stall = 1'b0; immB = 32'h0;
    mode = M_PLUS4; pc_next_man = 32'h0; ovr_en = 1'b0; ovr_word = 32'h0;
    tick(2);
    reset = 1'b0;

    // Reset state
    check("rst_pc",    pc, 32'h0);
    check("rst_req",   {31'b0, imemReq}, 32'h0);
    check("rst_valid", {31'b0, instrValid}, 32'h0);
    check("rst_count", {28'b0, instrCount}, 32'h0);

    // 1: sequential fetch, pc 0,4,8
    for (int i = 0; i < 3; i++) begin
      wait_valid(10);
      check("seq_pc", pc, 32'(i * 4));
      tick(1);
    end
    check("seq_count", {28'b0, instrCount}, 32'd3);
    check("seq_pc_end", pc, 32'hC);

    // 2: imem not ready for 5 cycles
    imemReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("wait_req",   {31'b0, imemReq}, 32'h1);
      check("wait_addr",  imemAddr, 32'hC);
      check("wait_valid", {31'b0, instrValid}, 32'h0);
    end
    ovr_en = 1'b1; ovr_word = 32'h0050_0093; imemReady = 1'b1;
    tick(1);
    check("ready_valid", {31'b0, instrValid}, 32'h1);
    check("ready_instr", instr, 32'h0050_0093);

    // 3: stall in VALID for 4 cycles
    stall = 1'b1; ovr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("stall_instr", instr, 32'h0050_0093);
      check("stall_pc",    pc, 32'hC);
      check("stall_count", {28'b0, instrCount}, 32'd3);
      check("stall_req",   {31'b0, imemReq}, 32'h0);
    end
    mode = M_MAN; pc_next_man = 32'h100; stall = 1'b0;
    tick(1);
    check("unstall_pc",    pc, 32'h100);
    check("unstall_count", {28'b0, instrCount}, 32'd4);
    check("unstall_req",   {31'b0, imemReq}, 32'h1);

    // 4: backward branch from 0x100
    immB = 32'hFFFF_FFF0;
    #1;
    check("br_target", pcBranch, 32'h0F0);
    wait_valid(10);
    mode = M_BRANCH;
    tick(1);
    check("br_pc",   pc, 32'h0F0);
    check("br_addr", imemAddr, 32'h0F0);

    // 5: wrap of pc + 4
    wait_valid(10);
    mode = M_MAN; pc_next_man = 32'hFFFF_FFFC;
    tick(1);
    check("top_pc",    pc, 32'hFFFF_FFFC);
    check("top_plus4", pcPlus4, 32'h0);
    wait_valid(10);
    mode = M_PLUS4;
    tick(1);
    check("wrap_pc",   pc, 32'h0);
    check("wrap_addr", imemAddr, 32'h0);
    check("wrap_req",  {31'b0, imemReq}, 32'h1);

    // 6: misaligned next PC
    wait_valid(10);
    mode = M_MAN; pc_next_man = 32'h102;
    tick(1);
    if (TRAP_EN) begin
      check("mis_flag", {31'b0, misaligned}, 32'h1);
      check("mis_pc",   pc, 32'h102);
      tick(3);
      check("mis_req",   {31'b0, imemReq}, 32'h0);
      check("mis_valid", {31'b0, instrValid}, 32'h0);
    end else begin
      check("mis_pc",   pc, 32'h100);
      check("mis_flag", {31'b0, misaligned}, 32'h0);
      check("mis_req",  {31'b0, imemReq}, 32'h1);
    end

    // Reset in the middle of a request
    mode = M_PLUS4;
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(1);
    check("pre_req", {31'b0, imemReq}, 32'h1);
    imemReady = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("mid_pc",    pc, 32'h0);
    check("mid_req",   {31'b0, imemReq}, 32'h0);
    check("mid_valid", {31'b0, instrValid}, 32'h0);
    check("mid_count", {28'b0, instrCount}, 32'h0);
    check("mid_instr", instr, 32'h0);
    check("mid_mis",   {31'b0, misaligned}, 32'h0);
    reset = 1'b0; imemReady = 1'b1;

    // Counter wrap: 17 accepts with a 4-bit counter
    accept_n(17);
    check("cnt_wrap", {28'b0, instrCount}, 32'd1);
    check("cnt_pc",   pc, 32'h44);

    // Mixed wait states and stalls; pcNext/immB junk when unused
    for (int i = 0; i < 80; i++) begin
      imemReady   = ($urandom_range(0, 9) < 6);
      stall       = ($urandom_range(0, 9) < 3);
      immB        = $urandom;
      pc_next_man = $urandom;
      tick(1);
    end

    stall = 1'b0; imemReady = 1'b1;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
